// File: rtl/fetch_pkg.sv
// Shared widths and FSM state encoding for the byte-serial instruction fetch unit.
package fetch_pkg;

    localparam int FLASH_ADDR_W    = 24;
    localparam int INSTR_W         = 32;
    localparam int BYTES_PER_INSTR = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        VALID = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Fetches 32-bit little-endian instructions one byte at a time from a fixed-latency flash.
// Optional build macro FETCH_MISALIGN_CHECK_EN turns misaligned redirects into a sticky fault.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                      READ_LATENCY = 3,
    parameter logic [FLASH_ADDR_W-1:0] RESET_ADDR   = 24'h000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fetch_en,
    input  logic                    redirect,
    input  logic [FLASH_ADDR_W-1:0] redirect_addr,
    output logic                    flash_re,
    output logic [FLASH_ADDR_W-1:0] flash_addr,
    input  logic [7:0]              flash_out,
    output logic [INSTR_W-1:0]      instr,
    output logic [FLASH_ADDR_W-1:0] instr_addr,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output logic                    fetch_fault
);

    localparam logic [2:0] LAST_LAT  = 3'(READ_LATENCY);
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_INSTR - 1);

    fetch_state_t            state;
    logic [FLASH_ADDR_W-1:0] pc;
    logic [1:0]              byte_idx;
    logic [2:0]              lat_cnt;
    logic                    fault_q;
    logic                    misaligned;
    logic                    can_fetch;
    logic [1:0]              next_byte;
    logic [FLASH_ADDR_W-1:0] pc_plus4;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misaligned  = (redirect_addr[1:0] != 2'b00);
    assign fetch_fault = fault_q;
`else
    assign misaligned  = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    assign can_fetch = fetch_en && !fault_q;
    assign next_byte = byte_idx + 2'd1;
    assign pc_plus4  = pc + FLASH_ADDR_W'(BYTES_PER_INSTR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_ADDR;
            byte_idx    <= 2'd0;
            lat_cnt     <= 3'd0;
            fault_q     <= 1'b0;
            instr       <= '0;
            instr_addr  <= RESET_ADDR;
            instr_valid <= 1'b0;
            flash_re    <= 1'b0;
            flash_addr  <= '0;
        end else if (redirect) begin
            // Redirect wins over everything, including a handshake in the same cycle.
            pc          <= redirect_addr;
            byte_idx    <= 2'd0;
            lat_cnt     <= 3'd0;
            instr_valid <= 1'b0;
            if (misaligned) begin
                fault_q  <= 1'b1;
                state    <= IDLE;
                flash_re <= 1'b0;
            end else begin
                state      <= READ;
                flash_re   <= 1'b1;
                flash_addr <= redirect_addr;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (can_fetch) begin
                        state      <= READ;
                        flash_re   <= 1'b1;
                        flash_addr <= pc;
                        byte_idx   <= 2'd0;
                        lat_cnt    <= 3'd0;
                    end
                end
                READ: begin
                    if (lat_cnt == LAST_LAT) begin
                        instr[{byte_idx, 3'b000} +: 8] <= flash_out;
                        lat_cnt <= 3'd0;
                        if (byte_idx == LAST_BYTE) begin
                            state       <= VALID;
                            flash_re    <= 1'b0;
                            instr_valid <= 1'b1;
                            instr_addr  <= pc;
                        end else begin
                            byte_idx   <= next_byte;
                            flash_addr <= pc + FLASH_ADDR_W'(next_byte);
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                VALID: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        pc          <= pc_plus4;
                        byte_idx    <= 2'd0;
                        lat_cnt     <= 3'd0;
                        if (can_fetch) begin
                            state      <= READ;
                            flash_re   <= 1'b1;
                            flash_addr <= pc_plus4;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
